// File: rtl/deser_pkg.sv
// Shared framing definitions for the serial link.
// Transmit and receive ends import these so both agree on the sync header.
package deser_pkg;

  localparam int unsigned SYNC_W_DEF = 8;
  localparam logic [7:0] SYNC_PATTERN_DEF = 8'hA5;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } deser_state_e;

endpackage

// File: rtl/deserializer_frame_cell_chk.sv
// Consistency checks on the deserializer status outputs.
module deserializer_frame_cell_chk (
  input logic clk,
  input logic rst_n,
  input logic par_valid,
  input logic locked,
  input logic sync_err
);

  a_valid_locked: assert property (@(posedge clk) disable iff (!rst_n) par_valid |-> locked);
  a_err_unlocked: assert property (@(posedge clk) disable iff (!rst_n) sync_err |-> !locked);
  a_valid_pulse:  assert property (@(posedge clk) disable iff (!rst_n) par_valid |=> !par_valid);
  a_err_pulse:    assert property (@(posedge clk) disable iff (!rst_n) sync_err |=> !sync_err);
  a_no_overlap:   assert property (@(posedge clk) disable iff (!rst_n) !(par_valid && sync_err));

endmodule

// File: rtl/sync_hunter.sv
// Sync header detector: SYNC_W-bit shift register plus look-ahead compare.
// The match uses the contents the register will hold after this clock.
module sync_hunter
  import deser_pkg::*;
#(
  parameter int unsigned SYNC_W = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_PATTERN_DEF)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in,
  output logic match
);

  logic [SYNC_W-1:0] hdr_r;
  logic [SYNC_W-1:0] hdr_next_s;

  // Next header contents and look-ahead compare
  always_comb begin
    hdr_next_s = {hdr_r[SYNC_W-2:0], serial_in};
    if (hdr_next_s == SYNC_PATTERN) begin
      match = 1'b1;
    end else begin
      match = 1'b0;
    end
  end

  // Header shift register, updated every clock in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_r <= '0;
    end else begin
      hdr_r <= hdr_next_s;
    end
  end

endmodule

// File: rtl/deserializer_frame_cell.sv
// Serial frame receiver: hunts for the sync header, captures one LSB-first
// payload word, and tracks link lock with a gap timeout.
module deserializer_frame_cell
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SYNC_W = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_PATTERN_DEF),
  parameter int unsigned MAX_GAP = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SERIAL_IN,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             PAR_VALID,
  output logic             LOCKED,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             SYNC_ERR
);

  localparam int unsigned BIT_CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = $clog2(MAX_GAP + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  deser_state_e           state_r;
  logic [BIT_CNT_W-1:0]   bit_cnt_r;
  logic [GAP_W-1:0]       gap_cnt_r;
  logic [WIDTH-2:0]       payload_r;
  logic [WIDTH-1:0]       par_out_r;
  logic                   par_valid_r;
  logic                   locked_r;
  logic [CNT_W-1:0]       frame_cnt_r;
  logic                   sync_err_r;
  logic                   match_s;

  sync_hunter #(
    .SYNC_W       (SYNC_W),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_sync_hunter (
    .clk       (CLK),
    .rst_n     (RESET),
    .serial_in (SERIAL_IN),
    .match     (match_s)
  );

  // Frame FSM, payload capture, lock tracking and status outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= HUNT;
      bit_cnt_r   <= '0;
      gap_cnt_r   <= '0;
      payload_r   <= '0;
      par_out_r   <= '0;
      par_valid_r <= 1'b0;
      locked_r    <= 1'b0;
      frame_cnt_r <= '0;
      sync_err_r  <= 1'b0;
    end else begin
      par_valid_r <= 1'b0;
      sync_err_r  <= 1'b0;
      case (state_r)
        HUNT: begin
          // A match on the timeout clock wins over the timeout
          if (match_s) begin
            state_r   <= PAYLOAD;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
          end else if (locked_r) begin
            if (gap_cnt_r == GAP_LAST) begin
              locked_r   <= 1'b0;
              sync_err_r <= 1'b1;
              gap_cnt_r  <= '0;
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
            end
          end else begin
            gap_cnt_r <= '0;
          end
        end
        PAYLOAD: begin
          if (bit_cnt_r == LAST_BIT) begin
            par_out_r   <= {SERIAL_IN, payload_r};
            par_valid_r <= 1'b1;
            locked_r    <= 1'b1;
            state_r     <= HUNT;
            gap_cnt_r   <= '0;
            bit_cnt_r   <= '0;
            if (frame_cnt_r != CNT_MAX) begin
              frame_cnt_r <= frame_cnt_r + CNT_W'(1'b1);
            end else begin
              frame_cnt_r <= frame_cnt_r;
            end
          end else begin
            payload_r[bit_cnt_r] <= SERIAL_IN;
            bit_cnt_r            <= bit_cnt_r + BIT_CNT_W'(1'b1);
          end
        end
        default: begin
          state_r <= HUNT;
        end
      endcase
    end
  end

  assign PAR_OUT   = par_out_r;
  assign PAR_VALID = par_valid_r;
  assign LOCKED    = locked_r;
  assign FRAME_CNT = frame_cnt_r;
  assign SYNC_ERR  = sync_err_r;

  deserializer_frame_cell_chk u_chk (
    .clk       (CLK),
    .rst_n     (RESET),
    .par_valid (par_valid_r),
    .locked    (locked_r),
    .sync_err  (sync_err_r)
  );

endmodule
